// File: rtl/mem_xbar_pkg.sv
// Shared types and address decode for the memory crossbar.
// MEM_XBAR_DECERR_EN: addresses above the Device window decode to an internal error target.
package mem_xbar_pkg;

    typedef enum logic [1:0] {TGT_DDR, TGT_DEV, TGT_ERR} tgt_e;

    localparam logic [31:0] DECERR_DATA = 32'hDEAD_BEEF;

    // 33-bit window compare so base+size may reach 2^32 without wrapping.
    function automatic tgt_e tgt_of(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] size);
        logic [32:0] w_end;
        w_end = {1'b0, base} + {1'b0, size};
        if ({1'b0, addr} >= {1'b0, base} && {1'b0, addr} < w_end) return TGT_DEV;
`ifdef MEM_XBAR_DECERR_EN
        if ({1'b0, addr} >= w_end) return TGT_ERR;
`endif
        return TGT_DDR;
    endfunction

endpackage

// File: rtl/mem_xbar_fifo.sv
// Small synchronous FIFO; used for the issue-order tag queue and the response buffer.
module mem_xbar_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push, w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the head slot in the same cycle, so push-when-full is fine alongside a pop.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_xbar.sv
// Routes one request stream to DDR/Device by address; buffers pulsed slave responses in order.
// MEM_XBAR_DECERR_EN: out-of-window addresses get an internal 0xDEADBEEF response.
module mem_xbar
    import mem_xbar_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] DEV_BASE = 32'h1000_0000,
    parameter logic [31:0] DEV_SIZE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        in_req_ready,
    input  logic        in_req_valid,
    input  logic [31:0] in_req_bits_addr,
    input  logic [31:0] in_req_bits_data,
    input  logic [1:0]  in_req_bits_len,
    input  logic        in_req_bits_func,
    input  logic [3:0]  in_req_bits_wstrb,
    input  logic        in_resp_ready,
    output logic        in_resp_valid,
    output logic [31:0] in_resp_bits_data,
    input  logic        ddr_req_ready,
    output logic        ddr_req_valid,
    output logic [31:0] ddr_req_bits_addr,
    output logic [31:0] ddr_req_bits_data,
    output logic [1:0]  ddr_req_bits_len,
    output logic        ddr_req_bits_func,
    output logic [3:0]  ddr_req_bits_wstrb,
    output logic        ddr_resp_ready,
    input  logic        ddr_resp_valid,
    input  logic [31:0] ddr_resp_bits_data,
    input  logic        dev_req_ready,
    output logic        dev_req_valid,
    output logic [31:0] dev_req_bits_addr,
    output logic [31:0] dev_req_bits_data,
    output logic [1:0]  dev_req_bits_len,
    output logic        dev_req_bits_func,
    output logic [3:0]  dev_req_bits_wstrb,
    output logic        dev_resp_ready,
    input  logic        dev_resp_valid,
    input  logic [31:0] dev_resp_bits_data
);
    localparam int CW = $clog2(DEPTH) + 1;

    tgt_e          w_tgt, w_resp_src, r_last_tgt;
    logic [CW-1:0] r_outst, w_rbuf_count, w_tag_count;
    logic [CW:0]   w_inflight;
    logic          r_err_pend;
    logic          w_sel_ready, w_credit_ok, w_order_ok, w_grant, w_accept;
    logic          w_resp_ev, w_resp_pop, w_resp_empty, w_resp_full;
    logic          w_tag_empty, w_tag_full;
    logic [1:0]    w_tag_head;
    logic [31:0]   w_resp_data;

    assign w_tgt = tgt_of(in_req_bits_addr, DEV_BASE, DEV_SIZE);

    always_comb begin
        w_sel_ready = 1'b1;
        case (w_tgt)
            TGT_DDR: w_sel_ready = ddr_req_ready;
            TGT_DEV: w_sel_ready = dev_req_ready;
            default: ;
        endcase
    end

    // Buffer occupancy plus requests still at a slave must fit in DEPTH: nothing can be dropped.
    assign w_inflight  = {1'b0, r_outst} + {1'b0, w_rbuf_count};
    assign w_credit_ok = w_inflight < (CW+1)'(DEPTH);
    assign w_order_ok  = (r_outst == '0) || (w_tgt == r_last_tgt);
    assign w_grant     = !reset && w_credit_ok && w_order_ok;
    assign in_req_ready = w_grant && w_sel_ready;
    assign w_accept     = in_req_valid && in_req_ready;

    // Slave valid is gated by grant so a slave never takes a request the core did not hand off.
    assign ddr_req_valid      = in_req_valid && w_grant && (w_tgt == TGT_DDR);
    assign ddr_req_bits_addr  = in_req_bits_addr;
    assign ddr_req_bits_data  = in_req_bits_data;
    assign ddr_req_bits_len   = in_req_bits_len;
    assign ddr_req_bits_func  = in_req_bits_func;
    assign ddr_req_bits_wstrb = in_req_bits_wstrb;
    assign dev_req_valid      = in_req_valid && w_grant && (w_tgt == TGT_DEV);
    assign dev_req_bits_addr  = in_req_bits_addr;
    assign dev_req_bits_data  = in_req_bits_data;
    assign dev_req_bits_len   = in_req_bits_len;
    assign dev_req_bits_func  = in_req_bits_func;
    assign dev_req_bits_wstrb = in_req_bits_wstrb;
    assign ddr_resp_ready     = 1'b1;
    assign dev_resp_ready     = 1'b1;

    always_comb begin
        w_resp_src  = TGT_ERR;
        w_resp_data = DECERR_DATA;
        if (ddr_resp_valid) begin
            w_resp_src  = TGT_DDR;
            w_resp_data = ddr_resp_bits_data;
        end else if (dev_resp_valid) begin
            w_resp_src  = TGT_DEV;
            w_resp_data = dev_resp_bits_data;
        end
    end

    assign w_resp_ev  = ddr_resp_valid || dev_resp_valid || r_err_pend;
    assign w_resp_pop = in_resp_valid && in_resp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outst    <= '0;
            r_last_tgt <= TGT_DDR;
            r_err_pend <= 1'b0;
        end else begin
            if (w_accept) r_last_tgt <= w_tgt;
            r_err_pend <= w_accept && (w_tgt == TGT_ERR);
            case ({w_accept, w_resp_ev})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: ;
            endcase
        end
    end

    mem_xbar_fifo #(.WIDTH(2), .DEPTH(DEPTH)) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_data  (w_tgt),
        .i_pop   (w_resp_ev),
        .o_data  (w_tag_head),
        .o_empty (w_tag_empty),
        .o_full  (w_tag_full),
        .o_count (w_tag_count)
    );

    mem_xbar_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_resp_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_resp_ev),
        .i_data  (w_resp_data),
        .i_pop   (w_resp_pop),
        .o_data  (in_resp_bits_data),
        .o_empty (w_resp_empty),
        .o_full  (w_resp_full),
        .o_count (w_rbuf_count)
    );

    assign in_resp_valid = !w_resp_empty;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(ddr_resp_valid && dev_resp_valid))
                else $error("mem_xbar: DDR and Device responded in the same cycle");
            if (w_resp_ev)
                assert (!w_tag_empty && (w_tag_head == w_resp_src))
                    else $error("mem_xbar: response from unexpected target");
            assert (w_tag_count == r_outst)
                else $error("mem_xbar: tag queue out of step with outstanding count");
            assert (!(w_tag_full && w_accept))
                else $error("mem_xbar: accept with tag queue full");
            assert (!(w_resp_full && w_resp_ev && !w_resp_pop))
                else $error("mem_xbar: response buffer overflow");
        end
    end
`endif

endmodule

// File: tb/tb_mem_xbar.sv
// Randomized bench for mem_xbar: slave models, a transaction-level reference model and a response scoreboard.
module tb_mem_xbar;
    localparam int DEPTH = 4;
    localparam int T_DDR = 0, T_DEV = 1, T_ERR = 2;

    logic        clk = 1'b0, reset = 1'b0;
    logic        in_req_ready, in_req_valid, in_req_bits_func, in_resp_ready, in_resp_valid;
    logic [31:0] in_req_bits_addr, in_req_bits_data, in_resp_bits_data;
    logic [1:0]  in_req_bits_len;
    logic [3:0]  in_req_bits_wstrb;
    logic        ddr_req_ready, ddr_req_valid, ddr_req_bits_func, ddr_resp_ready, ddr_resp_valid;
    logic [31:0] ddr_req_bits_addr, ddr_req_bits_data, ddr_resp_bits_data;
    logic [1:0]  ddr_req_bits_len;
    logic [3:0]  ddr_req_bits_wstrb;
    logic        dev_req_ready, dev_req_valid, dev_req_bits_func, dev_resp_ready, dev_resp_valid;
    logic [31:0] dev_req_bits_addr, dev_req_bits_data, dev_resp_bits_data;
    logic [1:0]  dev_req_bits_len;
    logic [3:0]  dev_req_bits_wstrb;

    always #5 clk = ~clk;

    mem_xbar #(.DEPTH(DEPTH), .DEV_BASE(32'h1000_0000), .DEV_SIZE(32'h1000_0000)) dut (
        .clk(clk), .reset(reset),
        .in_req_ready(in_req_ready), .in_req_valid(in_req_valid),
        .in_req_bits_addr(in_req_bits_addr), .in_req_bits_data(in_req_bits_data),
        .in_req_bits_len(in_req_bits_len), .in_req_bits_func(in_req_bits_func),
        .in_req_bits_wstrb(in_req_bits_wstrb), .in_resp_ready(in_resp_ready),
        .in_resp_valid(in_resp_valid), .in_resp_bits_data(in_resp_bits_data),
        .ddr_req_ready(ddr_req_ready), .ddr_req_valid(ddr_req_valid),
        .ddr_req_bits_addr(ddr_req_bits_addr), .ddr_req_bits_data(ddr_req_bits_data),
        .ddr_req_bits_len(ddr_req_bits_len), .ddr_req_bits_func(ddr_req_bits_func),
        .ddr_req_bits_wstrb(ddr_req_bits_wstrb), .ddr_resp_ready(ddr_resp_ready),
        .ddr_resp_valid(ddr_resp_valid), .ddr_resp_bits_data(ddr_resp_bits_data),
        .dev_req_ready(dev_req_ready), .dev_req_valid(dev_req_valid),
        .dev_req_bits_addr(dev_req_bits_addr), .dev_req_bits_data(dev_req_bits_data),
        .dev_req_bits_len(dev_req_bits_len), .dev_req_bits_func(dev_req_bits_func),
        .dev_req_bits_wstrb(dev_req_bits_wstrb), .dev_resp_ready(dev_resp_ready),
        .dev_resp_valid(dev_resp_valid), .dev_resp_bits_data(dev_resp_bits_data)
    );

    typedef struct packed { logic [31:0] data; int due; } sresp_t;
    sresp_t      ddr_q[$], dev_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] edge_a [6] = '{32'h0000_0040, 32'h0FFF_FFFF, 32'h1000_0000,
                               32'h1000_0004, 32'h1FFF_FFFF, 32'h2000_0000};
    int n_chk = 0, n_pass = 0, cyc = 0, n_dut_acc = 0;
    int p_valid = 70, p_rready = 70, p_sready = 75, last_tgt = T_DDR;
    bit acc_last = 0, err_pend = 0, ddr_only = 0;

    task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Address map from the block's documented windows, written directly as constants.
    function automatic int exp_tgt(logic [31:0] a);
        if (a >= 32'h1000_0000 && a <= 32'h1FFF_FFFF) return T_DEV;
`ifdef MEM_XBAR_DECERR_EN
        if (a >= 32'h2000_0000) return T_ERR;
`endif
        return T_DDR;
    endfunction

    function automatic logic [31:0] rnd_addr();
        if (ddr_only) return $urandom & 32'h0FFF_FFFC;
        case ($urandom_range(0, 4))
            0, 1:    return $urandom & 32'h0FFF_FFFF;
            2:       return 32'h1000_0000 | ($urandom & 32'h0FFF_FFFF);
            3:       return $urandom | 32'h2000_0000;
            default: return edge_a[$urandom_range(0, 5)];
        endcase
    endfunction

    function automatic bit coin(int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    task automatic drive();
        cyc++;
        ddr_resp_valid     = (ddr_q.size() > 0) && (ddr_q[0].due <= cyc);
        ddr_resp_bits_data = ddr_resp_valid ? ddr_q[0].data : $urandom;
        dev_resp_valid     = (dev_q.size() > 0) && (dev_q[0].due <= cyc);
        dev_resp_bits_data = dev_resp_valid ? dev_q[0].data : $urandom;
        ddr_req_ready = coin(p_sready);
        dev_req_ready = coin(p_sready);
        in_resp_ready = coin(p_rready);
        if (!(in_req_valid && !acc_last)) begin
            in_req_valid      = coin(p_valid);
            in_req_bits_addr  = rnd_addr();
            in_req_bits_data  = $urandom;
            in_req_bits_len   = 2'($urandom);
            in_req_bits_func  = 1'($urandom);
            in_req_bits_wstrb = 4'($urandom);
        end
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(posedge clk); #1;
            drive();
        end
    endtask

    // Reference model: predicts handshakes from occupancy/ordering rules, then advances one cycle.
    always @(negedge clk) begin
        int tgt, outst;
        bit sel, grant, rdy, acc;
        logic [31:0] d;
        if (reset) begin
            chk("rst_req_ready", in_req_ready, 0);
            chk("rst_resp_valid", in_resp_valid, 0);
            chk("rst_slave_valid", {ddr_req_valid, dev_req_valid}, 0);
            ddr_q.delete(); dev_q.delete(); exp_q.delete();
            err_pend = 0; last_tgt = T_DDR; acc_last = 0;
        end else if (cyc > 0) begin
            tgt   = exp_tgt(in_req_bits_addr);
            outst = ddr_q.size() + dev_q.size() + int'(err_pend);
            sel   = (tgt == T_DDR) ? ddr_req_ready : (tgt == T_DEV) ? dev_req_ready : 1'b1;
            grant = (exp_q.size() < DEPTH) && (outst == 0 || tgt == last_tgt);
            rdy   = grant && sel;
            acc   = in_req_valid && rdy;
            chk("in_req_ready", in_req_ready, rdy);
            chk("ddr_req_valid", ddr_req_valid, in_req_valid && grant && tgt == T_DDR);
            chk("dev_req_valid", dev_req_valid, in_req_valid && grant && tgt == T_DEV);
            chk("in_resp_valid", in_resp_valid, exp_q.size() > outst);
            if (ddr_req_valid)
                chk("ddr_req_fields", {ddr_req_bits_addr, ddr_req_bits_data, ddr_req_bits_len,
                    ddr_req_bits_func, ddr_req_bits_wstrb}, {in_req_bits_addr, in_req_bits_data,
                    in_req_bits_len, in_req_bits_func, in_req_bits_wstrb});
            if (dev_req_valid)
                chk("dev_req_fields", {dev_req_bits_addr, dev_req_bits_data, dev_req_bits_len,
                    dev_req_bits_func, dev_req_bits_wstrb}, {in_req_bits_addr, in_req_bits_data,
                    in_req_bits_len, in_req_bits_func, in_req_bits_wstrb});
            if (in_req_valid && in_req_ready) n_dut_acc++;
            if (ddr_resp_valid) void'(ddr_q.pop_front());
            if (dev_resp_valid) void'(dev_q.pop_front());
            err_pend = 0;
            if (acc) begin
                d = $urandom;
                last_tgt = tgt;
                case (tgt)
                    T_DDR: begin ddr_q.push_back('{d, cyc + 1 + int'($urandom_range(0, 3))}); exp_q.push_back(d); end
                    T_DEV: begin dev_q.push_back('{d, cyc + 1 + int'($urandom_range(0, 3))}); exp_q.push_back(d); end
                    default: begin err_pend = 1; exp_q.push_back(32'hDEAD_BEEF); end
                endcase
            end
            acc_last = acc;
        end
    end

    // Scoreboard monitor: every response the core takes must match the oldest expected one.
    always @(posedge clk) begin
        if (!reset && in_resp_valid && in_resp_ready) begin
            if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
            else chk("resp_data", in_resp_bits_data, exp_q.pop_front());
        end
    end

    initial begin
        in_req_valid = 0; in_req_bits_addr = 0; in_req_bits_data = 0; in_req_bits_len = 0;
        in_req_bits_func = 0; in_req_bits_wstrb = 0; in_resp_ready = 0;
        ddr_req_ready = 0; dev_req_ready = 0; ddr_resp_valid = 0; dev_resp_valid = 0;
        ddr_resp_bits_data = 0; dev_resp_bits_data = 0;
        #2 reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        drive();
        chk("resp_ready_tied", {ddr_resp_ready, dev_resp_ready}, 2'b11);
        run(1500);

        // Drain, then hold the core off responses and push DDR reads: only DEPTH may be taken.
        p_valid = 0; p_rready = 100; run(40);
        chk("drained", exp_q.size(), 0);
        ddr_only = 1; p_valid = 100; p_rready = 0; n_dut_acc = 0; run(30);
        chk("stall_at_depth", n_dut_acc, DEPTH);
        p_rready = 100; run(30);
        ddr_only = 0;

        // Reset with requests in flight.
        p_valid = 90; p_rready = 0; run(6);
        @(posedge clk); #1 reset = 1; drive();
        @(posedge clk); #1 reset = 0; drive();
        p_valid = 70; p_rready = 70; run(1500);

        p_valid = 0; p_rready = 100; run(40);
        chk("final_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
